// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, EX redirect and data-memory wait into stage enables/flushes.
// Outputs are combinational from state and inputs (zero latency); a memory access freezes the whole pipe until release.
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_mem_op,
  input  logic             dmem_done,
  output logic             dmem_start,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic           w_freeze, w_timeout, w_load_use, w_redirect;

  assign w_load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_freeze       = 1'b0;
    w_timeout      = 1'b0;
    w_redirect     = 1'b0;
    dmem_start     = 1'b0;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ex_mem_mem_op) begin
          dmem_start     = 1'b1;
          w_freeze       = 1'b1;
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (dmem_done) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == WCW'(TIMEOUT)) begin
          // completion wins over timeout when both land in the same cycle
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_freeze       = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (rst) begin
      dmem_start   = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (w_freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_redirect  = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      mem_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (!pc_en)     stall_cnt <= stall_cnt + CNT_W'(1);
      if (w_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
      if (w_timeout)  mem_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-count reference model.
module tb_pipeline_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd, if_id_rs1, if_id_rs2;
  logic             ex_branch_taken, ex_mem_mem_op, dmem_done;
  logic             dmem_start, pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .ex_branch_taken(ex_branch_taken), .ex_mem_mem_op(ex_mem_mem_op),
    .dmem_done(dmem_done), .dmem_start(dmem_start),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an access is described by k = cycles elapsed since its start cycle.
  bit m_busy = 0;
  int m_k    = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_err  = 0;

  // Inputs must already be driven; checks this cycle, then advances one clock.
  task automatic step();
    logic [7:0] e_ctl;
    bit e_start, e_pc, e_ifid, e_idex, e_exmem, e_fifid, e_fidex, e_fmemwb;
    bit freeze, redirect, tmo, busy_n, lu;
    int k_n;
    e_start = 0; e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
    e_fifid = 0; e_fidex = 0; e_fmemwb = 0;
    freeze = 0; redirect = 0; tmo = 0; busy_n = m_busy; k_n = m_k;
    lu = id_ex_mem_read && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    if (!m_busy) begin
      if (ex_mem_mem_op) begin
        e_start = 1; freeze = 1; busy_n = 1; k_n = 1;
      end
    end else if (dmem_done || m_k == TIMEOUT + 1) begin
      busy_n = 0; tmo = !dmem_done;
    end else begin
      freeze = 1; k_n = m_k + 1;
    end
    if (rst) begin
      e_start = 0; e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0;
      e_fifid = 1; e_fidex = 1; e_fmemwb = 1;
    end else if (freeze) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_fmemwb = 1;
    end else if (ex_branch_taken) begin
      e_fifid = 1; e_fidex = 1; redirect = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_fidex = 1;
    end
    e_ctl = {e_start, e_pc, e_ifid, e_idex, e_exmem, e_fifid, e_fidex, e_fmemwb};
    #3;
    chk("ctl", {24'd0, dmem_start, pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, mem_wb_flush}, {24'd0, e_ctl});
    chk("stall_cnt", {24'd0, stall_cnt}, m_stall);
    chk("flush_cnt", {24'd0, flush_cnt}, m_flush);
    chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_k = 0; m_stall = 0; m_flush = 0; m_err = 0;
    end else begin
      m_busy = busy_n; m_k = k_n;
      if (!e_pc) m_stall = (m_stall + 1) % (1 << CNT_W);
      if (redirect) m_flush = (m_flush + 1) % (1 << CNT_W);
      if (tmo) m_err = 1;
    end
    #1;
  endtask

  task automatic quiet();
    rst = 0; id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    ex_branch_taken = 0; ex_mem_mem_op = 0; dmem_done = 0;
  endtask

  int base;

  initial begin
    quiet();
    rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    chk("rst_stall", {24'd0, stall_cnt}, 0);
    chk("rst_err", {31'd0, mem_err}, 0);

    // load-use: lw x5 then add x6,x5,x1
    id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs1 = 5; if_id_rs2 = 1;
    step();
    chk("lu_stall", {24'd0, stall_cnt}, 1);
    id_ex_rd = 0; if_id_rs1 = 0;
    step();
    chk("lu_x0", {24'd0, stall_cnt}, 1);

    // redirect overrides load-use
    id_ex_rd = 7; if_id_rs2 = 7; ex_branch_taken = 1;
    #0 chk("redir_pc", {31'd0, pc_en}, 1);
    step();
    chk("redir_flush", {24'd0, flush_cnt}, 1);
    chk("redir_stall", {24'd0, stall_cnt}, 1);
    quiet();

    // memory access with latency 3
    base = stall_cnt;
    ex_mem_mem_op = 1;
    step();
    step(); step();
    dmem_done = 1;
    step();
    quiet();
    step();
    chk("mem_l3_stall", {24'd0, stall_cnt}, base + 3);

    // branch held in EX across a 2-cycle wait
    base = flush_cnt;
    ex_mem_mem_op = 1; ex_branch_taken = 1;
    step(); step();
    dmem_done = 1;
    step();
    ex_mem_mem_op = 0; dmem_done = 0; ex_branch_taken = 0;
    step();
    chk("held_branch", {24'd0, flush_cnt}, base + 1);

    // timeout: start + TIMEOUT wait-freeze cycles, then release
    base = stall_cnt;
    ex_mem_mem_op = 1;
    step();
    ex_mem_mem_op = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) step();
    chk("tmo_err", {31'd0, mem_err}, 1);
    chk("tmo_stall", {24'd0, stall_cnt}, base + TIMEOUT + 1);
    step(); step();
    chk("tmo_sticky", {31'd0, mem_err}, 1);

    // reset in the middle of a wait
    ex_mem_mem_op = 1;
    step(); step();
    rst = 1;
    step();
    rst = 0; ex_mem_mem_op = 0; dmem_done = 1;
    chk("mid_rst_err", {31'd0, mem_err}, 0);
    step();
    dmem_done = 0; ex_mem_mem_op = 1;
    #0 chk("fresh_start", {31'd0, dmem_start}, 1);
    step();
    dmem_done = 1; ex_mem_mem_op = 0;
    step();
    quiet();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst             = ($urandom_range(0, 79) == 0);
      id_ex_mem_read  = $urandom_range(0, 1);
      id_ex_rd        = 5'($urandom_range(0, 3));
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      ex_mem_mem_op   = ($urandom_range(0, 2) == 0);
      dmem_done       = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
